video_gray_converter: RTL and testbench

Downstream consumer of the RGB pattern/video source. Pulls 24-bit RGB pixels by driving `VideoReady` and converts each pixel to 8-bit luma through a 2-stage pipeline. Buffers the results in a small FIFO and presents them on a valid/ready stream tagged with start-of-frame and end-of-line flags. This stream is the grayscale input to the SIFT front end.

---
 rtl/video_gray_converter.sv | 159 +++++++++++++++
 tb/tb_video_gray_converter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_gray_converter.sv
// RGB-to-luma converter: pulls 24-bit pixels, emits 8-bit Y tagged with sof/eol through a small FWFT FIFO.
// Latency: a pixel captured at edge k is written to the FIFO at edge k+2 and is visible from then on.
// Backpressure: credit-based; VideoReady drops once FIFO occupancy plus in-flight pixels reach FIFO_DEPTH.
module video_gray_converter #(
  parameter int H_ACTIVE   = 800,
  parameter int V_ACTIVE   = 600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Enable,
  input  logic [23:0] video,
  output logic        VideoReady,
  output logic [7:0]  gray_data,
  output logic        gray_sof,
  output logic        gray_eol,
  output logic        gray_valid,
  input  logic        gray_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 2;
  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  // Raster position of the next pixel to be captured
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  // Stage 1: weighted colour products
  logic [15:0] pr_q, pg_q, pb_q;
  logic        s1_vld_q, s1_sof_q, s1_eol_q;

  // Stage 2: luma
  logic [7:0]  y_lum_q;
  logic        s2_vld_q, s2_sof_q, s2_eol_q;
  logic [15:0] lum_sum;

  // FIFO storage: {sof, eol, Y}
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [9:0]    head;
  logic          push, pop, capture;
  logic [CW-1:0] credits;

  // Credits count every pixel already accepted but not yet popped, so the FIFO can never overflow.
  assign credits    = CW'(count_q) + CW'(s1_vld_q) + CW'(s2_vld_q);
  assign VideoReady = Reset & Enable & (credits < CW'(FIFO_DEPTH));
  assign capture    = VideoReady;
  assign push       = s2_vld_q;
  assign pop        = gray_valid & gray_ready;

  // Next raster position; only a capture moves it, so an Enable gap holds the position
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (capture) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Raster counter registers
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // Stage 1: register the three products and the position flags of the captured pixel
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      s1_vld_q <= 1'b0;
      s1_sof_q <= 1'b0;
      s1_eol_q <= 1'b0;
      pr_q     <= '0;
      pg_q     <= '0;
      pb_q     <= '0;
    end else begin
      s1_vld_q <= capture;
      if (capture) begin
        pr_q     <= 16'd77  * {8'd0, video[23:16]};
        pg_q     <= 16'd150 * {8'd0, video[15:8]};
        pb_q     <= 16'd29  * {8'd0, video[7:0]};
        s1_sof_q <= (x_q == '0) && (y_q == '0);
        s1_eol_q <= (x_q == X_LAST);
      end
    end
  end

  // Weights sum to 256, so the sum of products never exceeds 65280 and fits 16 bits
  assign lum_sum = pr_q + pg_q + pb_q;

  // Stage 2: truncate the weighted sum to 8-bit luma
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      s2_vld_q <= 1'b0;
      s2_sof_q <= 1'b0;
      s2_eol_q <= 1'b0;
      y_lum_q  <= '0;
    end else begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        y_lum_q  <= lum_sum[15:8];
        s2_sof_q <= s1_sof_q;
        s2_eol_q <= s1_eol_q;
      end
    end
  end

  // FIFO storage write; contents need no reset because the outputs are gated by occupancy
  always_ff @(posedge Clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s2_sof_q, s2_eol_q, y_lum_q};
    end
  end

  // Occupancy next state; simultaneous push and pop cancel
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and occupancy; pointer width makes the wrap modulo FIFO_DEPTH
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // First-word-fall-through head, forced to zero while empty
  assign head       = mem_q[rd_ptr_q];
  assign gray_valid = (count_q != '0);
  assign gray_data  = gray_valid ? head[7:0] : 8'd0;
  assign gray_eol   = gray_valid & head[8];
  assign gray_sof   = gray_valid & head[9];

endmodule

// File: tb/tb_video_gray_converter.sv
// Directed bench for video_gray_converter with a 4x2 raster and a 4-entry FIFO.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// A falling-edge monitor logs pops, counts captures and tracks outstanding pixels.
module tb_video_gray_converter;

  localparam int H = 4;
  localparam int V = 2;
  localparam int D = 4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Enable = 1'b0;
  logic        gray_ready = 1'b0;
  logic [23:0] video = 24'd0;
  logic        VideoReady;
  logic [7:0]  gray_data;
  logic        gray_sof;
  logic        gray_eol;
  logic        gray_valid;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int cap_cnt = 0;
  int occ = 0;
  int max_occ = 0;
  logic [9:0] pop_q [$];
  int         pop_cyc [$];

  video_gray_converter #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .FIFO_DEPTH (D)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Enable     (Enable),
    .video      (video),
    .VideoReady (VideoReady),
    .gray_data  (gray_data),
    .gray_sof   (gray_sof),
    .gray_eol   (gray_eol),
    .gray_valid (gray_valid),
    .gray_ready (gray_ready)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc++;

  // Log what the next rising edge will capture and pop
  always @(negedge Clock) begin
    if (!Reset) begin
      occ = 0;
    end else begin
      if (VideoReady) begin
        cap_cnt++;
        occ++;
      end
      if (gray_valid && gray_ready) begin
        pop_q.push_back({gray_sof, gray_eol, gray_data});
        pop_cyc.push_back(cyc);
        occ--;
      end
      if (occ > max_occ) max_occ = occ;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic smp;
    @(negedge Clock);
  endtask

  task automatic drv;
    @(posedge Clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drv;
  endtask

  task automatic reset_dut;
    Reset = 1'b0;
    Enable = 1'b1;
    gray_ready = 1'b0;
    drv;
    drv;
    smp;
    check("rst_vr_low", VideoReady, 0);
    check("rst_valid", gray_valid, 0);
    check("rst_data", gray_data, 0);
    check("rst_sof", gray_sof, 0);
    check("rst_eol", gray_eol, 0);
    drv;
    Reset = 1'b1;
    Enable = 1'b0;
  endtask

  logic [23:0] tbl [4];
  logic        vr [8];
  logic [15:0] eol_mask;
  logic [15:0] sof_mask;
  int b, c0, c1, idx;

  initial begin
    tbl[0] = 24'hE67E22;  // {230,126,34} -> 146
    tbl[1] = 24'hFFFFFF;  // -> 255
    tbl[2] = 24'h000000;  // -> 0
    tbl[3] = 24'h1ABC9C;  // {26,188,156} -> 135

    // Single pixel: latency and sof
    reset_dut;
    video = 24'h1ABC9C;
    Enable = 1'b1;
    gray_ready = 1'b1;
    smp;
    check("sp_vr", VideoReady, 1);
    drv;
    Enable = 1'b0;
    smp;
    check("sp_valid_k1", gray_valid, 0);
    drv;
    smp;
    check("sp_valid_k2", gray_valid, 0);
    drv;
    smp;
    check("sp_valid", gray_valid, 1);
    check("sp_data", gray_data, 135);
    check("sp_sof", gray_sof, 1);
    check("sp_eol", gray_eol, 0);
    drv;
    smp;
    check("sp_popped", gray_valid, 0);
    drv;

    // Corner values streamed back-to-back
    reset_dut;
    b = pop_q.size();
    Enable = 1'b1;
    gray_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      video = tbl[i];
      smp;
      check("st_vr", VideoReady, 1);
      drv;
    end
    Enable = 1'b0;
    idle(6);
    check("st_count", pop_q.size() - b, 3);
    if (pop_q.size() - b == 3) begin
      check("st_y0", int'(pop_q[b][7:0]), 146);
      check("st_y1", int'(pop_q[b+1][7:0]), 255);
      check("st_y2", int'(pop_q[b+2][7:0]), 0);
      check("st_gap01", pop_cyc[b+1] - pop_cyc[b], 1);
      check("st_gap12", pop_cyc[b+2] - pop_cyc[b+1], 1);
    end

    // Backpressure from reset, then resume
    reset_dut;
    b = pop_q.size();
    c0 = cap_cnt;
    Enable = 1'b1;
    gray_ready = 1'b0;
    idx = 0;
    video = tbl[0];
    for (int i = 0; i < 8; i++) begin
      smp;
      vr[i] = VideoReady;
      drv;
      if (vr[i]) idx++;
      video = (idx < 4) ? tbl[idx] : 24'hFFFFFF;
    end
    check("bp_vr_3", int'(vr[3]), 1);
    check("bp_vr_4", int'(vr[4]), 0);
    check("bp_vr_7", int'(vr[7]), 0);
    check("bp_caps", cap_cnt - c0, 4);
    gray_ready = 1'b1;
    smp;
    check("bp_vr_full", VideoReady, 0);
    check("bp_valid", gray_valid, 1);
    check("bp_head", gray_data, 146);
    drv;
    smp;
    check("bp_resume", VideoReady, 1);
    drv;
    Enable = 1'b0;
    idle(8);
    check("bp_count", pop_q.size() - b, 5);
    if (pop_q.size() - b == 5) begin
      check("bp_y0", int'(pop_q[b][7:0]), 146);
      check("bp_y1", int'(pop_q[b+1][7:0]), 255);
      check("bp_y2", int'(pop_q[b+2][7:0]), 0);
      check("bp_y3", int'(pop_q[b+3][7:0]), 135);
      check("bp_y4", int'(pop_q[b+4][7:0]), 255);
      check("bp_drain_gapless", pop_cyc[b+3] - pop_cyc[b], 3);
    end

    // Raster flags over two frames of 4x2
    reset_dut;
    b = pop_q.size();
    c0 = cap_cnt;
    Enable = 1'b1;
    gray_ready = 1'b1;
    video = 24'h404040;  // -> 64
    idle(16);
    Enable = 1'b0;
    idle(6);
    check("rf_caps", cap_cnt - c0, 16);
    check("rf_count", pop_q.size() - b, 16);
    eol_mask = 16'h8888;
    sof_mask = 16'h0101;
    if (pop_q.size() - b == 16) begin
      check("rf_y", int'(pop_q[b][7:0]), 64);
      for (int j = 0; j < 16; j++) begin
        check($sformatf("rf_eol%0d", j), int'(pop_q[b+j][8]), int'(eol_mask[j]));
        check($sformatf("rf_sof%0d", j), int'(pop_q[b+j][9]), int'(sof_mask[j]));
      end
    end

    // Enable gap mid-line
    reset_dut;
    b = pop_q.size();
    c0 = cap_cnt;
    Enable = 1'b1;
    gray_ready = 1'b1;
    video = 24'h000000;
    idle(2);
    Enable = 1'b0;
    c1 = cap_cnt;
    idle(3);
    check("eg_gap_caps", cap_cnt - c1, 0);
    Enable = 1'b1;
    idle(6);
    Enable = 1'b0;
    idle(6);
    check("eg_caps", cap_cnt - c0, 8);
    check("eg_count", pop_q.size() - b, 8);
    if (pop_q.size() - b == 8) begin
      for (int j = 0; j < 8; j++) begin
        check($sformatf("eg_eol%0d", j), int'(pop_q[b+j][8]), int'(eol_mask[j]));
        check($sformatf("eg_sof%0d", j), int'(pop_q[b+j][9]), int'(sof_mask[j]));
      end
    end

    // Reset mid-frame with the FIFO and both pipeline stages occupied
    reset_dut;
    Enable = 1'b1;
    gray_ready = 1'b0;
    video = 24'hFFFFFF;
    idle(4);
    Reset = 1'b0;
    smp;
    check("mr_vr_low", VideoReady, 0);
    check("mr_pre_valid", gray_valid, 1);
    drv;
    Reset = 1'b1;
    Enable = 1'b0;
    b = pop_q.size();
    smp;
    check("mr_valid", gray_valid, 0);
    check("mr_data", gray_data, 0);
    drv;
    video = 24'h1ABC9C;
    Enable = 1'b1;
    gray_ready = 1'b1;
    smp;
    check("mr_vr", VideoReady, 1);
    drv;
    Enable = 1'b0;
    idle(6);
    check("mr_count", pop_q.size() - b, 1);
    if (pop_q.size() - b == 1) begin
      check("mr_sof", int'(pop_q[b][9]), 1);
      check("mr_y", int'(pop_q[b][7:0]), 135);
    end

    check("no_overflow", int'(max_occ <= D), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
